// File: rtl/game_session_ctrl.sv
// game_session_ctrl: runs one game session after the credit stage reports a
// spendable credit. It debounces-by-synchronising the start button, issues a
// one-cycle startGameNow to spend the credit, then counts guesses until a win,
// or until MAX_ROUNDS misses end the game as a loss.
//
// Optional build macro: ROUND_TIMEOUT_EN adds a per-round timer. After
// TIMEOUT_CYCLES cycles in PLAY without a guess, the round counts as an
// incorrect guess.
//
// Ports:
//   CLOCK_50      in   system clock
//   reset_L       in   asynchronous active-low reset
//   startButton   in   raw start button (asynchronous, active-high)
//   ready         in   credit available, code loaded, no game running
//   guessSubmit   in   one-cycle pulse, a guess has been scored
//   guessCorrect  in   qualified by guessSubmit, the guess matched
//   clearGame     in   return to idle from WIN/LOSE
//   startGameNow  out  one-cycle pulse, spend one credit
//   gamePlaying   out  game in progress (START or PLAY)
//   gameWon       out  last game ended with a correct guess
//   gameLost      out  last game used all rounds
//   roundNum      out  guesses consumed in current/last game
module game_session_ctrl #(
   parameter int unsigned MAX_ROUNDS     = 10,
   parameter int unsigned TIMEOUT_CYCLES = 1500000000
) (
   input  logic       CLOCK_50,
   input  logic       reset_L,
   input  logic       startButton,
   input  logic       ready,
   input  logic       guessSubmit,
   input  logic       guessCorrect,
   input  logic       clearGame,
   output logic       startGameNow,
   output logic       gamePlaying,
   output logic       gameWon,
   output logic       gameLost,
   output logic [3:0] roundNum
);

   localparam int unsigned RW = 4;
   localparam int unsigned CW = 32;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_PLAY,
      S_WIN,
      S_LOSE
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [RW-1:0]   r_round;
   logic [RW-1:0]   w_round_next;

   logic            r_sync1;
   logic            r_sync2;
   logic            r_sync3;
   logic            r_start_req;

   logic            r_start_now;
   logic            r_playing;
   logic            r_won;
   logic            r_lost;

   logic            w_start_ok;
   logic            w_expire;
   logic            w_miss;

   // Two-flop synchroniser, then a registered rising-edge detect.
   always_ff @(posedge CLOCK_50 or negedge reset_L) begin
      if (!reset_L) begin
         r_sync1     <= 1'b0;
         r_sync2     <= 1'b0;
         r_sync3     <= 1'b0;
         r_start_req <= 1'b0;
      end else begin
         r_sync1     <= startButton;
         r_sync2     <= r_sync1;
         r_sync3     <= r_sync2;
         r_start_req <= r_sync2 & ~r_sync3;
      end
   end

   assign w_start_ok = r_start_req & ready;

`ifdef ROUND_TIMEOUT_EN
   logic [CW-1:0] r_tmo_cnt;

   // A guess in the expiry cycle takes priority, so expiry needs no guess.
   assign w_expire = (r_state == S_PLAY) && !guessSubmit &&
                     (r_tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

   // Round timer: counts only while staying in PLAY without a guess.
   always_ff @(posedge CLOCK_50 or negedge reset_L) begin
      if (!reset_L) begin
         r_tmo_cnt <= '0;
      end else if ((r_state != S_PLAY) || (w_next != S_PLAY) ||
                   guessSubmit || w_expire) begin
         r_tmo_cnt <= '0;
      end else begin
         r_tmo_cnt <= r_tmo_cnt + CW'(1);
      end
   end
`else
   logic w_unused_tmo;
   assign w_unused_tmo = ^(CW'(TIMEOUT_CYCLES));
   assign w_expire     = 1'b0;
`endif

   // An expired round is handled exactly like a wrong guess.
   assign w_miss = (guessSubmit & ~guessCorrect) | w_expire;

   // Next-state and round counter.
   always_comb begin
      w_next       = r_state;
      w_round_next = r_round;
      case (r_state)
         S_IDLE: begin
            if (w_start_ok) begin
               w_next       = S_START;
               w_round_next = '0;
            end
         end
         S_START: begin
            w_next = S_PLAY;
         end
         S_PLAY: begin
            if (guessSubmit && guessCorrect) begin
               w_next       = S_WIN;
               w_round_next = r_round + RW'(1);
            end else if (w_miss) begin
               if (r_round == RW'(MAX_ROUNDS - 1)) begin
                  w_next       = S_LOSE;
                  w_round_next = RW'(MAX_ROUNDS);
               end else begin
                  w_round_next = r_round + RW'(1);
               end
            end
         end
         S_WIN, S_LOSE: begin
            // A replay request beats a simultaneous clear.
            if (w_start_ok) begin
               w_next       = S_START;
               w_round_next = '0;
            end else if (clearGame) begin
               w_next = S_IDLE;
            end
         end
         default: begin
            w_next       = S_IDLE;
            w_round_next = '0;
         end
      endcase
   end

   // State register with outputs registered from the next state.
   always_ff @(posedge CLOCK_50 or negedge reset_L) begin
      if (!reset_L) begin
         r_state     <= S_IDLE;
         r_round     <= '0;
         r_start_now <= 1'b0;
         r_playing   <= 1'b0;
         r_won       <= 1'b0;
         r_lost      <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_round     <= w_round_next;
         r_start_now <= (w_next == S_START);
         r_playing   <= (w_next == S_START) || (w_next == S_PLAY);
         r_won       <= (w_next == S_WIN);
         r_lost      <= (w_next == S_LOSE);
      end
   end

   assign startGameNow = r_start_now;
   assign gamePlaying  = r_playing;
   assign gameWon      = r_won;
   assign gameLost     = r_lost;
   assign roundNum     = r_round;

endmodule
